e_mdu_ctrl: RTL and testbench

//  E-stage multiply/divide sequencer beside the ALU. Accepts one MD op per start pulse,

---
 rtl/e_mdu_ctrl_if.sv | 40 ++++
 rtl/e_mdu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_e_mdu_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_ctrl_if.sv
// E-stage multiply/divide bus between the pipeline (master) and the MD sequencer (slave).
// Optional abort line E_MDUFlush exists only when MDU_FLUSH_EN is defined.
interface e_mdu_ctrl_if;
    logic [3:0]  E_MDUOp;
    logic        E_MDUStart;
    logic [31:0] E_MDUA;
    logic [31:0] E_MDUB;
    logic        E_MDUBusy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
`ifdef MDU_FLUSH_EN
    logic        E_MDUFlush;
`endif

    modport master (
`ifdef MDU_FLUSH_EN
        output E_MDUFlush,
`endif
        output E_MDUOp,
        output E_MDUStart,
        output E_MDUA,
        output E_MDUB,
        input  E_MDUBusy,
        input  E_HI,
        input  E_LO
    );

    modport slave (
`ifdef MDU_FLUSH_EN
        input  E_MDUFlush,
`endif
        input  E_MDUOp,
        input  E_MDUStart,
        input  E_MDUA,
        input  E_MDUB,
        output E_MDUBusy,
        output E_HI,
        output E_LO
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: latches an MD result at start, holds Busy for a fixed
// latency, then commits to HI/LO. Optional in-flight abort enabled by defining MDU_FLUSH_EN.
module e_mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    e_mdu_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } op_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_ph, w_ph_nxt;
    logic [31:0]      r_pl, w_pl_nxt;

    logic        w_flush;
    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;

`ifdef MDU_FLUSH_EN
    assign w_flush = bus.E_MDUFlush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_op = bus.E_MDUOp;
    assign w_a  = bus.E_MDUA;
    assign w_b  = bus.E_MDUB;

    // ---------------- datapath: one multiplier, one unsigned divider on magnitudes ----------
    logic        w_is_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_a_neg     = w_is_signed & w_a[31];
    assign w_b_neg     = w_is_signed & w_b[31];

    // Sign- or zero-extending to 64 bits makes the truncated product correct for both flavours.
    assign w_ext_a = {{32{w_a_neg}}, w_a};
    assign w_ext_b = {{32{w_b_neg}}, w_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Magnitude division keeps -2^31 / -1 well defined (wraps to 0x80000000, remainder 0).
    assign w_mag_a = w_a_neg ? (~w_a + 32'd1) : w_a;
    assign w_mag_b = w_b_neg ? (~w_b + 32'd1) : w_b;
    assign w_den   = (w_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag = w_mag_a / w_den;
    assign w_r_mag = w_mag_a % w_den;

    always_comb begin
        if (w_b == 32'd0) begin
            w_quot = 32'hFFFF_FFFF;
            w_rem  = w_a;
        end else begin
            w_quot = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
            w_rem  = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        // NOTE: every next-value gets its hold default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_ph_nxt    = r_ph;
        w_pl_nxt    = r_pl;

        unique case (r_state)
            S_IDLE: begin
                if (bus.E_MDUStart && !w_flush) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: begin
                            w_ph_nxt    = w_prod[63:32];
                            w_pl_nxt    = w_prod[31:0];
                            w_state_nxt = S_MUL;
                            w_count_nxt = MUL_LOAD;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_ph_nxt    = w_rem;
                            w_pl_nxt    = w_quot;
                            w_state_nxt = S_DIV;
                            w_count_nxt = DIV_LOAD;
                        end
                        OP_MTHI: w_hi_nxt = w_a;
                        OP_MTLO: w_lo_nxt = w_a;
                        default: ;
                    endcase
                end
            end

            S_MUL, S_DIV: begin
                // Start is deliberately ignored here; an abort beats a same-edge commit.
                if (w_flush) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (r_count == CNT_ONE) begin
                    w_hi_nxt    = r_ph;
                    w_lo_nxt    = r_pl;
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: plain registers, not a memory, so all of them (pending result too) reset here.
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_ph    <= w_ph_nxt;
            r_pl    <= w_pl_nxt;
        end
    end

    assign bus.E_MDUBusy = (r_state != S_IDLE);
    assign bus.E_HI      = r_hi;
    assign bus.E_LO      = r_lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl with hand-computed HI/LO results and Busy timing.
// Flush scenarios are compiled in only when MDU_FLUSH_EN is defined.
module tb_e_mdu_ctrl;

    localparam int unsigned MUL_C = 5;
    localparam int unsigned DIV_C = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic clk;
    logic reset_n;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu_ctrl_if bus ();

    e_mdu_ctrl #(
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one start for a single edge; returns at the negedge after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.E_MDUOp    = op;
        bus.E_MDUA     = a;
        bus.E_MDUB     = b;
        bus.E_MDUStart = 1'b1;
        @(negedge clk);
        bus.E_MDUStart = 1'b0;
        bus.E_MDUOp    = OP_NONE;
    endtask

    // Multi-cycle op: Busy for exactly 'cycles' sampled cycles, old HI/LO held until commit.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        check({tag, "_busy0"}, 32'(bus.E_MDUBusy), 32'd1);
        check({tag, "_hi_hold"}, bus.E_HI, m_hi);
        check({tag, "_lo_hold"}, bus.E_LO, m_lo);
        for (int i = 1; i < int'(cycles); i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(bus.E_MDUBusy), 32'd1);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.E_MDUBusy), 32'd0);
        check({tag, "_hi"}, bus.E_HI, exp_hi);
        check({tag, "_lo"}, bus.E_LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.E_MDUOp    = OP_NONE;
        bus.E_MDUStart = 1'b0;
        bus.E_MDUA     = '0;
        bus.E_MDUB     = '0;
`ifdef MDU_FLUSH_EN
        bus.E_MDUFlush = 1'b0;
`endif
        m_hi = '0;
        m_lo = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("rst_hi", bus.E_HI, 32'd0);
        check("rst_lo", bus.E_LO, 32'd0);
        reset_n = 1'b1;

        run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, MUL_C, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_C, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, DIV_C, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", OP_DIVU,  32'd7,         32'd0, DIV_C, 32'd7,         32'hFFFF_FFFF);
        run_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_C, 32'd0, 32'h8000_0000);
        run_op("div0s", OP_DIV,   32'hFFFF_FFFB, 32'd0, DIV_C, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("divu",  OP_DIVU,  32'hFFFF_FFF9, 32'd2, DIV_C, 32'd1,         32'h7FFF_FFFC);

        // mthi/mtlo write next edge without Busy; unused opcodes do nothing
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("mthi_hi", bus.E_HI, 32'h0000_1234);
        check("mthi_lo", bus.E_LO, m_lo);
        m_hi = 32'h0000_1234;
        issue(OP_MTLO, 32'h0000_5678, 32'd0);
        check("mtlo_lo", bus.E_LO, 32'h0000_5678);
        m_lo = 32'h0000_5678;
        issue(4'd9, 32'hDEAD_BEEF, 32'd3);
        check("op9_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("op9_hi", bus.E_HI, m_hi);
        check("op9_lo", bus.E_LO, m_lo);

        // div 100/7 with a mtlo and a mult thrown at it while busy: both ignored
        issue(OP_DIV, 32'd100, 32'd7);
        bus.E_MDUOp = OP_MTLO; bus.E_MDUA = 32'hDEAD_0000; bus.E_MDUStart = 1'b1;
        @(negedge clk);
        bus.E_MDUStart = 1'b0; bus.E_MDUOp = OP_NONE;
        check("busy_mtlo_lo", bus.E_LO, m_lo);
        check("busy_mtlo_busy", 32'(bus.E_MDUBusy), 32'd1);
        repeat (6) @(negedge clk);
        bus.E_MDUOp = OP_MULT; bus.E_MDUA = 32'd9; bus.E_MDUB = 32'd9; bus.E_MDUStart = 1'b1;
        @(negedge clk);
        bus.E_MDUStart = 1'b0; bus.E_MDUOp = OP_NONE;
        @(negedge clk);
        check("busy_mul_n9", 32'(bus.E_MDUBusy), 32'd1);
        check("busy_mul_hi9", bus.E_HI, m_hi);
        @(negedge clk);
        check("busy_mul_done", 32'(bus.E_MDUBusy), 32'd0);
        check("busy_mul_hi", bus.E_HI, 32'd2);
        check("busy_mul_lo", bus.E_LO, 32'd14);
        @(negedge clk);
        check("busy_mul_nodbl", 32'(bus.E_MDUBusy), 32'd0);
        check("busy_mul_hi2", bus.E_HI, 32'd2);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // async reset in cycle 3 of a mult, then a clean mult
        issue(OP_MULT, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        check("rmid_busy_pre", 32'(bus.E_MDUBusy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rmid_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("rmid_hi", bus.E_HI, 32'd0);
        check("rmid_lo", bus.E_LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post_rst", OP_MULT, 32'hFFFF_FFFD, 32'd4, MUL_C, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

`ifdef MDU_FLUSH_EN
        issue(OP_MTHI, 32'd5, 32'd0);
        issue(OP_MTLO, 32'd6, 32'd0);
        m_hi = 32'd5;
        m_lo = 32'd6;
        issue(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        bus.E_MDUFlush = 1'b1;
        @(negedge clk);
        bus.E_MDUFlush = 1'b0;
        check("fl_div_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("fl_div_hi", bus.E_HI, 32'd5);
        check("fl_div_lo", bus.E_LO, 32'd6);

        @(negedge clk);
        bus.E_MDUOp = OP_MTHI; bus.E_MDUA = 32'd99; bus.E_MDUStart = 1'b1; bus.E_MDUFlush = 1'b1;
        @(negedge clk);
        bus.E_MDUStart = 1'b0; bus.E_MDUOp = OP_NONE; bus.E_MDUFlush = 1'b0;
        check("fl_idle_hi", bus.E_HI, 32'd5);

        issue(OP_MULT, 32'd3, 32'd3);
        repeat (MUL_C - 1) @(negedge clk);
        bus.E_MDUFlush = 1'b1;
        @(negedge clk);
        bus.E_MDUFlush = 1'b0;
        check("fl_last_busy", 32'(bus.E_MDUBusy), 32'd0);
        check("fl_last_hi", bus.E_HI, 32'd5);
        check("fl_last_lo", bus.E_LO, 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
